// File: rtl/axi_single_arbiter.sv
// Round-robin arbiter sharing one AXI3 master port among N req/ack clients, single-beat only.
// One transfer outstanding; ack_o pulses in the third cycle after the grant edge with a zero-wait slave.
module axi_single_arbiter #(
  parameter int N  = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              aclk_i,
  input  logic              arstn_i,
  input  logic [N-1:0]      req_i,
  input  logic [N-1:0]      we_i,
  input  logic [N*AW-1:0]   addr_i,
  input  logic [N*DW-1:0]   wdata_i,
  output logic [N-1:0]      ack_o,
  output logic [DW-1:0]     rdata_o,
  output logic              err_o,
  output logic [3:0]        awid_o,
  output logic [AW-1:0]     awaddr_o,
  output logic [3:0]        awlen_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  output logic [1:0]        awlock_o,
  output logic [3:0]        awcache_o,
  output logic [2:0]        awprot_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [3:0]        wid_o,
  output logic [DW-1:0]     wdata_o,
  output logic [DW/8-1:0]   wstrb_o,
  output logic              wlast_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  output logic [3:0]        arid_o,
  output logic [AW-1:0]     araddr_o,
  output logic [3:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic [1:0]        arlock_o,
  output logic [3:0]        arcache_o,
  output logic [2:0]        arprot_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DW-1:0]     rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  input  logic              rlast_i,
  output logic              rready_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d, rr_q, rr_d, pick;
  logic          found;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic          bready_q, bready_d, rready_q, rready_d, err_q, err_d;
  logic          unused_rlast;

  // Single-beat reads make rlast redundant.
  assign unused_rlast = rlast_i;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[(int'(rr_q) + i) % N]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_q) + i) % N);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          rr_d    = (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
          addr_d  = addr_i[int'(pick) * AW +: AW];
          wdata_d = wdata_i[int'(pick) * DW +: DW];
          if (we_i[pick]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WADDR: begin
        if (awvalid_q && awready_i) awvalid_d = 1'b0;
        if (wvalid_q && wready_i)   wvalid_d  = 1'b0;
        // A channel is finished if it handshook earlier or is handshaking now.
        if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (bvalid_i) begin
          err_d    = |bresp_i;
          bready_d = 1'b0;
          state_d  = DONE;
        end
      end
      RADDR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (rvalid_i) begin
          rdata_d  = rdata_i;
          err_d    = |rresp_i;
          rready_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rr_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
    end
  end

  always_comb begin
    ack_o = '0;
    if (state_q == DONE) ack_o[gnt_q] = 1'b1;
  end

  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign awid_o    = '0;
  assign awaddr_o  = addr_q;
  assign awlen_o   = '0;
  assign awsize_o  = 3'($clog2(DW / 8));
  assign awburst_o = 2'b00;
  assign awlock_o  = '0;
  assign awcache_o = '0;
  assign awprot_o  = '0;
  assign awvalid_o = awvalid_q;
  assign wid_o     = '0;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = '1;
  assign wlast_o   = wvalid_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;
  assign arid_o    = '0;
  assign araddr_o  = addr_q;
  assign arlen_o   = '0;
  assign arsize_o  = 3'($clog2(DW / 8));
  assign arburst_o = 2'b00;
  assign arlock_o  = '0;
  assign arcache_o = '0;
  assign arprot_o  = '0;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;
endmodule
